rob_multi_commit: RTL and testbench

Parametrised reorder buffer, the successor to the single-commit ROB. It sits between the decoder, the execution units (ALU/RS, LSB, future units), and the register file. It accepts one instruction per cycle in program order and takes results from `WB_PORTS` independent writeback ports. It retires up to `COMMIT_WIDTH` consecutive ready entries per cycle, and raises a registered one-cycle flush on a branch mispredict.

---
 rtl/rob_multi_commit.sv | 206 ++++++++++++++++++++
 tb/tb_rob_multi_commit.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_commit.sv
// rob_multi_commit
//   Reorder buffer with 2^DEPTH_BIT entries, WB_PORTS writeback ports and up to
//   COMMIT_WIDTH in-order retirements per cycle. A mispredicted branch produces
//   a registered one-cycle flush that empties the buffer.
// Ports:
//   clk_in, rst_n_in (async, active-low), rdy_in (stall when low)
//   alloc_*          : one program-order allocation per cycle at the tail
//   wb_*             : per-port writeback strobe, entry id and value (lane k = slice k)
//   q_id*/q_ready*/q_value* : operand lookups with same-cycle bypass
//   full/empty/count/head_id/tail_id : occupancy and pointers
//   commit_*         : per-lane register-file write for retiring RG entries
//   set_dep_*        : RG allocation notice to the rename/dependency logic
//   flush/flush_pc   : registered mispredict redirect
//   halt, overflow_err, committed_count : sticky status and retirement counter
module rob_multi_commit #(
  parameter int DEPTH_BIT    = 3,
  parameter int WB_PORTS     = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            rdy_in,
  input  logic                            alloc_valid,
  input  logic [1:0]                      alloc_type,
  input  logic [4:0]                      alloc_rd,
  input  logic                            alloc_done,
  input  logic [31:0]                     alloc_value,
  input  logic [31:0]                     alloc_jump_addr,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS*DEPTH_BIT-1:0]   wb_rob_id,
  input  logic [WB_PORTS*32-1:0]          wb_value,
  input  logic [DEPTH_BIT-1:0]            q_id1,
  input  logic [DEPTH_BIT-1:0]            q_id2,
  output logic                            q_ready1,
  output logic                            q_ready2,
  output logic [31:0]                     q_value1,
  output logic [31:0]                     q_value2,
  output logic                            full,
  output logic                            empty,
  output logic [DEPTH_BIT:0]              count,
  output logic [DEPTH_BIT-1:0]            head_id,
  output logic [DEPTH_BIT-1:0]            tail_id,
  output logic [COMMIT_WIDTH-1:0]         commit_valid,
  output logic [COMMIT_WIDTH*5-1:0]       commit_rd,
  output logic [COMMIT_WIDTH*32-1:0]      commit_value,
  output logic [COMMIT_WIDTH*DEPTH_BIT-1:0] commit_rob_id,
  output logic                            set_dep_valid,
  output logic [4:0]                      set_dep_rd,
  output logic [DEPTH_BIT-1:0]            set_dep_rob_id,
  output logic                            flush,
  output logic [31:0]                     flush_pc,
  output logic                            halt,
  output logic                            overflow_err,
  output logic [15:0]                     committed_count
);

  localparam int DEPTH = 1 << DEPTH_BIT;
  // Entry types: RG=0 (register write), ST=1, BR=2, EX=3
  localparam logic [1:0] T_RG = 2'd0;
  localparam logic [1:0] T_BR = 2'd2;
  localparam logic [1:0] T_EX = 2'd3;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] jump_addr;
  } entry_t;

  entry_t                 ent [DEPTH];
  logic [DEPTH_BIT-1:0]   head, tail;

  logic                   active, alloc_ok, chain, mispredict, ex_ret;
  logic [COMMIT_WIDTH-1:0] ret;
  logic [DEPTH_BIT-1:0]   lane_id [COMMIT_WIDTH];
  logic [DEPTH_BIT:0]     n_ret;
  logic [31:0]            mis_pc;
  entry_t                 alloc_entry;

  assign full    = (count == (DEPTH_BIT+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head_id = head;
  assign tail_id = tail;

  // Lookup priority: stored ready entry, then same-cycle writeback (highest
  // port wins), then a same-cycle ready allocation at the tail.
  function automatic logic [32:0] lookup(input logic [DEPTH_BIT-1:0] id);
    logic [32:0] r;
    logic        hit;
    r   = {1'b0, ent[id].value};
    hit = 1'b0;
    if (ent[id].ready) begin
      r = {1'b1, ent[id].value};
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && wb_rob_id[p*DEPTH_BIT +: DEPTH_BIT] == id) begin
          r   = {1'b1, wb_value[p*32 +: 32]};
          hit = 1'b1;
        end
      end
      if (!hit && alloc_valid && alloc_done && tail == id)
        r = {1'b1, alloc_value};
    end
    return r;
  endfunction

  always_comb begin
    logic [32:0] l1, l2;
    l1 = lookup(q_id1);
    l2 = lookup(q_id2);
    q_ready1 = l1[32];
    q_value1 = l1[31:0];
    q_ready2 = l2[32];
    q_value2 = l2[31:0];
  end

  always_comb begin
    // Nothing retires or allocates during a stall or the flush cycle.
    active   = rdy_in && !flush;
    alloc_ok = active && alloc_valid && !full;

    alloc_entry = '{busy: 1'b1, ready: alloc_done, typ: alloc_type, rd: alloc_rd,
                    value: alloc_value, jump_addr: alloc_jump_addr};

    set_dep_valid  = alloc_ok && (alloc_type == T_RG);
    set_dep_rd     = alloc_rd;
    set_dep_rob_id = tail;

    ret           = '0;
    n_ret         = '0;
    mispredict    = 1'b0;
    mis_pc        = '0;
    ex_ret        = 1'b0;
    commit_valid  = '0;
    commit_rd     = '0;
    commit_value  = '0;
    commit_rob_id = '0;
    chain         = active && !halt;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      lane_id[k] = head + DEPTH_BIT'(k);
      ret[k]     = chain && ent[lane_id[k]].busy && ent[lane_id[k]].ready;
      // A BR or EX closes the group so redirect/halt take effect before
      // anything younger retires.
      chain      = ret[k] && (ent[lane_id[k]].typ != T_BR) && (ent[lane_id[k]].typ != T_EX);
      if (ret[k]) begin
        n_ret = n_ret + 1'b1;
        if (ent[lane_id[k]].typ == T_BR &&
            (ent[lane_id[k]].value[0] ^ ent[lane_id[k]].jump_addr[0])) begin
          mispredict = 1'b1;
          mis_pc     = {ent[lane_id[k]].jump_addr[31:1], 1'b0};
        end
        if (ent[lane_id[k]].typ == T_EX) ex_ret = 1'b1;
      end
      commit_valid[k]                      = ret[k] && (ent[lane_id[k]].typ == T_RG);
      commit_rd[k*5 +: 5]                  = ent[lane_id[k]].rd;
      commit_value[k*32 +: 32]             = ent[lane_id[k]].value;
      commit_rob_id[k*DEPTH_BIT +: DEPTH_BIT] = lane_id[k];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      flush           <= 1'b0;
      flush_pc        <= '0;
      halt            <= 1'b0;
      overflow_err    <= 1'b0;
      committed_count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        flush <= 1'b0;
      end else begin
        // Later ports overwrite earlier ones on an id collision.
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && ent[wb_rob_id[p*DEPTH_BIT +: DEPTH_BIT]].busy) begin
            ent[wb_rob_id[p*DEPTH_BIT +: DEPTH_BIT]].ready <= 1'b1;
            ent[wb_rob_id[p*DEPTH_BIT +: DEPTH_BIT]].value <= wb_value[p*32 +: 32];
          end
        end
        for (int k = 0; k < COMMIT_WIDTH; k++)
          if (ret[k]) ent[lane_id[k]] <= '0;
        if (alloc_ok) ent[tail] <= alloc_entry;
        if (alloc_valid && full) overflow_err <= 1'b1;
        head            <= head + n_ret[DEPTH_BIT-1:0];
        tail            <= tail + DEPTH_BIT'(alloc_ok);
        count           <= count + (DEPTH_BIT+1)'(alloc_ok) - n_ret;
        committed_count <= committed_count + 16'(n_ret);
        if (ex_ret) halt <= 1'b1;
        if (mispredict) begin
          flush    <= 1'b1;
          flush_pc <= mis_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
module tb_rob_multi_commit;

  localparam int DB = 3;
  localparam int WP = 2;
  localparam int CW = 2;

  logic            clk_in = 1'b0;
  logic            rst_n_in = 1'b0;
  logic            rdy_in;
  logic            alloc_valid;
  logic [1:0]      alloc_type;
  logic [4:0]      alloc_rd;
  logic            alloc_done;
  logic [31:0]     alloc_value;
  logic [31:0]     alloc_jump_addr;
  logic [WP-1:0]   wb_valid;
  logic [WP*DB-1:0] wb_rob_id;
  logic [WP*32-1:0] wb_value;
  logic [DB-1:0]   q_id1, q_id2;
  logic            q_ready1, q_ready2;
  logic [31:0]     q_value1, q_value2;
  logic            full, empty;
  logic [DB:0]     count;
  logic [DB-1:0]   head_id, tail_id;
  logic [CW-1:0]   commit_valid;
  logic [CW*5-1:0] commit_rd;
  logic [CW*32-1:0] commit_value;
  logic [CW*DB-1:0] commit_rob_id;
  logic            set_dep_valid;
  logic [4:0]      set_dep_rd;
  logic [DB-1:0]   set_dep_rob_id;
  logic            flush;
  logic [31:0]     flush_pc;
  logic            halt, overflow_err;
  logic [15:0]     committed_count;

  int vectors = 0;
  int miscompares = 0;

  rob_multi_commit #(.DEPTH_BIT(DB), .WB_PORTS(WP), .COMMIT_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_done(alloc_done), .alloc_value(alloc_value), .alloc_jump_addr(alloc_jump_addr),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .q_id1(q_id1), .q_id2(q_id2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2),
    .full(full), .empty(empty), .count(count), .head_id(head_id), .tail_id(tail_id),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_id(commit_rob_id),
    .set_dep_valid(set_dep_valid), .set_dep_rd(set_dep_rd), .set_dep_rob_id(set_dep_rob_id),
    .flush(flush), .flush_pc(flush_pc), .halt(halt), .overflow_err(overflow_err),
    .committed_count(committed_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in          = 1'b1;
    alloc_valid     = 1'b0;
    alloc_type      = 2'd0;
    alloc_rd        = 5'd0;
    alloc_done      = 1'b0;
    alloc_value     = 32'd0;
    alloc_jump_addr = 32'd0;
    wb_valid        = '0;
    wb_rob_id       = '0;
    wb_value        = '0;
    q_id1           = '0;
    q_id2           = '0;
  endtask

  task automatic set_alloc(input logic [1:0] t, input logic [4:0] rd, input logic done,
                           input logic [31:0] val, input logic [31:0] ja);
    alloc_valid     = 1'b1;
    alloc_type      = t;
    alloc_rd        = rd;
    alloc_done      = done;
    alloc_value     = val;
    alloc_jump_addr = ja;
  endtask

  task automatic set_wb(input int p, input logic [DB-1:0] id, input logic [31:0] val);
    wb_valid[p]              = 1'b1;
    wb_rob_id[p*DB +: DB]    = id;
    wb_value[p*32 +: 32]     = val;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    vectors++;
    if ({empty, full, count, head_id, tail_id} !== {1'b1, 1'b0, 4'd0, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_occupancy: empty=%b full=%b count=%0d head=%0d tail=%0d, expected 1 0 0 0 0",
               empty, full, count, head_id, tail_id);
    end
    vectors++;
    if ({flush, halt, overflow_err, flush_pc, committed_count, commit_valid} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: flush=%b halt=%b ovf=%b pc=%h cc=%0d cv=%b, expected all 0",
               flush, halt, overflow_err, flush_pc, committed_count, commit_valid);
    end
    rst_n_in = 1'b1;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(2'd0, 5'(i + 1), 1'b0, 32'd0, 32'd0);
      tick();
    end
    vectors++;
    if ({full, count, tail_id, head_id} !== {1'b1, 4'd8, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL fill_full: full=%b count=%0d tail=%0d head=%0d, expected 1 8 0 0",
               full, count, tail_id, head_id);
    end
    // Ninth allocation while full.
    vectors++;
    if (set_dep_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_setdep_full: got %b expected 0", set_dep_valid);
    end
    tick();
    alloc_valid = 1'b0;
    vectors++;
    if ({overflow_err, count} !== {1'b1, 4'd8}) begin
      miscompares++;
      $display("FAIL fill_overflow: ovf=%b count=%0d, expected 1 8", overflow_err, count);
    end
    set_wb(0, 3'd0, 32'h100);
    set_wb(1, 3'd1, 32'h101);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        set_wb(0, 3'(2*k + 2), 32'h100 + 32'(2*k + 2));
        set_wb(1, 3'(2*k + 3), 32'h100 + 32'(2*k + 3));
      end else begin
        wb_valid = '0;
      end
      #1;
      vectors++;
      if ({commit_valid, commit_rob_id} !== {2'b11, 3'(2*k + 1), 3'(2*k)}) begin
        miscompares++;
        $display("FAIL drain_commit_%0d: valid=%b ids=%h, expected 11 %h", k,
                 commit_valid, commit_rob_id, {3'(2*k + 1), 3'(2*k)});
      end
      vectors++;
      if ({commit_rd, commit_value} !== {5'(2*k + 2), 5'(2*k + 1),
                                         32'h100 + 32'(2*k + 1), 32'h100 + 32'(2*k)}) begin
        miscompares++;
        $display("FAIL drain_data_%0d: rd=%h value=%h", k, commit_rd, commit_value);
      end
      tick();
    end
    vectors++;
    if ({committed_count, empty, tail_id, head_id} !== {16'd8, 1'b1, 3'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL drain_end: cc=%0d empty=%b tail=%0d head=%0d, expected 8 1 0 0",
               committed_count, empty, tail_id, head_id);
    end
  endtask

  task automatic test_wb_collision();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(2'd0, 5'(i + 10), 1'b0, 32'd0, 32'd0);
      tick();
    end
    alloc_valid = 1'b0;
    set_wb(0, 3'd3, 32'h11);
    set_wb(1, 3'd3, 32'h22);
    q_id1 = 3'd3;
    q_id2 = 3'd2;
    #1;
    vectors++;
    if ({q_ready1, q_value1} !== {1'b1, 32'h22}) begin
      miscompares++;
      $display("FAIL collision_bypass: ready=%b value=%h, expected 1 00000022", q_ready1, q_value1);
    end
    vectors++;
    if (q_ready2 !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_unready_q2: got %b expected 0", q_ready2);
    end
    tick();
    wb_valid = '0;
    #1;
    vectors++;
    if ({q_ready1, q_value1, commit_valid} !== {1'b1, 32'h22, 2'b00}) begin
      miscompares++;
      $display("FAIL collision_stored: ready=%b value=%h cv=%b, expected 1 00000022 00",
               q_ready1, q_value1, commit_valid);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_alloc(2'd2, 5'd0, 1'b0, 32'd0, 32'h1000);
    tick();
    set_alloc(2'd0, 5'd5, 1'b1, 32'h55, 32'd0);
    tick();
    alloc_valid = 1'b0;
    set_wb(0, 3'd0, 32'd1);
    tick();
    wb_valid = '0;
    #1;
    vectors++;
    if ({commit_valid, count} !== {2'b00, 4'd2}) begin
      miscompares++;
      $display("FAIL mispredict_group: cv=%b count=%0d, expected 00 2", commit_valid, count);
    end
    tick();
    vectors++;
    if ({flush, flush_pc, count, head_id, committed_count} !== {1'b1, 32'h1000, 4'd1, 3'd1, 16'd1}) begin
      miscompares++;
      $display("FAIL mispredict_flush: flush=%b pc=%h count=%0d head=%0d cc=%0d, expected 1 00001000 1 1 1",
               flush, flush_pc, count, head_id, committed_count);
    end
    vectors++;
    if (commit_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL mispredict_flush_nocommit: got %b expected 00", commit_valid);
    end
    rdy_in = 1'b0;
    tick();
    vectors++;
    if (flush !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_hold_stall: got %b expected 1", flush);
    end
    rdy_in = 1'b1;
    set_alloc(2'd0, 5'd6, 1'b1, 32'h66, 32'd0);
    #1;
    vectors++;
    if (set_dep_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_alloc_blocked: got %b expected 0", set_dep_valid);
    end
    tick();
    alloc_valid = 1'b0;
    vectors++;
    if ({flush, count, head_id, tail_id, empty, committed_count} !== {1'b0, 4'd0, 3'd0, 3'd0, 1'b1, 16'd1}) begin
      miscompares++;
      $display("FAIL mispredict_after: flush=%b count=%0d head=%0d tail=%0d empty=%b cc=%0d, expected 0 0 0 0 1 1",
               flush, count, head_id, tail_id, empty, committed_count);
    end
  endtask

  task automatic test_commit_group();
    do_reset();
    set_alloc(2'd0, 5'd7, 1'b1, 32'h77, 32'd0);
    tick();
    set_alloc(2'd3, 5'd0, 1'b1, 32'd0, 32'd0);
    #1;
    vectors++;
    if ({commit_valid, commit_rd[4:0], commit_value[31:0]} !== {2'b01, 5'd7, 32'h77}) begin
      miscompares++;
      $display("FAIL group_rg: cv=%b rd=%0d value=%h, expected 01 7 00000077",
               commit_valid, commit_rd[4:0], commit_value[31:0]);
    end
    tick();
    set_alloc(2'd0, 5'd9, 1'b1, 32'h99, 32'd0);
    #1;
    vectors++;
    if ({commit_valid, head_id} !== {2'b00, 3'd1}) begin
      miscompares++;
      $display("FAIL group_ex_lane: cv=%b head=%0d, expected 00 1", commit_valid, head_id);
    end
    tick();
    alloc_valid = 1'b0;
    vectors++;
    if ({halt, committed_count, commit_valid} !== {1'b1, 16'd2, 2'b00}) begin
      miscompares++;
      $display("FAIL group_halt: halt=%b cc=%0d cv=%b, expected 1 2 00", halt, committed_count, commit_valid);
    end
    tick();
    vectors++;
    if ({count, head_id, committed_count} !== {4'd1, 3'd2, 16'd2}) begin
      miscompares++;
      $display("FAIL group_halted: count=%0d head=%0d cc=%0d, expected 1 2 2", count, head_id, committed_count);
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    set_alloc(2'd0, 5'd3, 1'b1, 32'h33, 32'd0);
    tick();
    rdy_in = 1'b0;
    set_alloc(2'd0, 5'd4, 1'b1, 32'h44, 32'd0);
    #1;
    vectors++;
    if ({commit_valid, set_dep_valid} !== {2'b00, 1'b0}) begin
      miscompares++;
      $display("FAIL stall_outputs: cv=%b setdep=%b, expected 00 0", commit_valid, set_dep_valid);
    end
    tick();
    vectors++;
    if ({count, tail_id, committed_count} !== {4'd1, 3'd1, 16'd0}) begin
      miscompares++;
      $display("FAIL stall_hold: count=%0d tail=%0d cc=%0d, expected 1 1 0", count, tail_id, committed_count);
    end
    rdy_in = 1'b1;
    alloc_valid = 1'b0;
    #1;
    vectors++;
    if ({commit_valid, commit_rd[4:0]} !== {2'b01, 5'd3}) begin
      miscompares++;
      $display("FAIL stall_release: cv=%b rd=%0d, expected 01 3", commit_valid, commit_rd[4:0]);
    end
    rst_n_in = 1'b0;
    #1;
    vectors++;
    if ({count, empty, tail_id, commit_valid} !== {4'd0, 1'b1, 3'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL async_reset: count=%0d empty=%b tail=%0d cv=%b, expected 0 1 0 00",
               count, empty, tail_id, commit_valid);
    end
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_wb_collision();
    test_mispredict();
    test_commit_group();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
